scoreboard_display: RTL

Downstream consumer of the game controller's `time_left`, `blue_score` and `red_score` outputs. It drives seven active-low seven-segment digits:

- three digits for time in seconds;
- two digits for the blue score;
- two digits for the red score.

A single shared iterative binary-to-BCD engine (shift-add-3) serves the three channels round-robin. Time digits blink once `time_left` reaches zero. Board-level pin mapping of the seven digit outputs is done in the top level.

---
 rtl/scoreboard_display.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/scoreboard_display.sv
// -----------------------------------------------------------------------------
// scoreboard_display
//
// Converts the game controller's time and score values to seven active-low
// seven-segment digits. One shift-add-3 binary-to-BCD engine is shared
// round-robin by the time, blue and red channels. Each channel takes
// 10 cycles (LOAD, 8x SHIFT, STORE), so a full frame takes 30 cycles.
// Time digits blink once the displayed time is zero.
//
// Parameters:
//   BLINK_HALF_PERIOD   clk cycles per blink half-phase (visible / blank)
//   BLANK_LEADING_ZEROS 1 = suppress leading zero digits, 0 = show all digits
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   time_left  [7:0]    remaining seconds, 0..255
//   blue_score [6:0]    blue score, 0..127 (shown saturated at 99)
//   red_score  [6:0]    red score, 0..127 (shown saturated at 99)
//   hex_time2/1/0       time hundreds/tens/ones, active-low, bit0=a..bit6=g
//   hex_blue1/0         blue tens/ones
//   hex_red1/0          red tens/ones
//   frame_done          one-cycle pulse when the red channel is stored
// -----------------------------------------------------------------------------
module scoreboard_display #(
    parameter int unsigned BLINK_HALF_PERIOD   = 25000000,
    parameter bit          BLANK_LEADING_ZEROS = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] time_left,
    input  logic [6:0] blue_score,
    input  logic [6:0] red_score,
    output logic [6:0] hex_time2,
    output logic [6:0] hex_time1,
    output logic [6:0] hex_time0,
    output logic [6:0] hex_blue1,
    output logic [6:0] hex_blue0,
    output logic [6:0] hex_red1,
    output logic [6:0] hex_red0,
    output logic       frame_done
);

    localparam int unsigned          BLINK_W    = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;
    localparam logic [BLINK_W-1:0]   BLINK_LAST = BLINK_W'(BLINK_HALF_PERIOD - 1);
    localparam logic [6:0]           SEG_BLANK  = 7'h7F;
    localparam logic [7:0]           SCORE_MAX  = 8'd99;

    typedef enum logic [1:0] {ST_LOAD, ST_SHIFT, ST_STORE} state_e;
    typedef enum logic [1:0] {CH_TIME, CH_BLUE, CH_RED}    ch_e;

    // Active-low segment pattern for one decimal digit.
    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    seg_encode = 7'h40;
            4'd1:    seg_encode = 7'h79;
            4'd2:    seg_encode = 7'h24;
            4'd3:    seg_encode = 7'h30;
            4'd4:    seg_encode = 7'h19;
            4'd5:    seg_encode = 7'h12;
            4'd6:    seg_encode = 7'h02;
            4'd7:    seg_encode = 7'h78;
            4'd8:    seg_encode = 7'h00;
            4'd9:    seg_encode = 7'h10;
            default: seg_encode = SEG_BLANK;
        endcase
    endfunction

    // Shift-add-3 correction: any nibble >= 5 would overflow past 9 when
    // doubled by the following shift, so bias it by 3 first.
    function automatic logic [11:0] bcd_adjust(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int i = 0; i < 3; i++) begin
            if (r[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    state_e               state_q, state_d;
    ch_e                  ch_q, ch_d;
    logic [7:0]           bin_q, bin_d;
    logic [11:0]          bcd_q, bcd_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [6:0]           t2_q, t2_d, t1_q, t1_d, t0_q, t0_d;
    logic [6:0]           b1_q, b1_d, b0_q, b0_d;
    logic [6:0]           r1_q, r1_d, r0_q, r0_d;
    // Set when the last stored time value was zero; clear out of reset so
    // nothing blinks before the first time conversion.
    logic                 time_zero_q, time_zero_d;
    logic                 frame_done_q, frame_done_d;
    logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic                 blink_phase_q, blink_phase_d;

    logic [7:0]           sel;
    logic [11:0]          adj;
    logic [3:0]           dig_h, dig_t, dig_o;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case statements leaves a signal unassigned (no latches).
        state_d       = state_q;
        ch_d          = ch_q;
        bin_d         = bin_q;
        bcd_d         = bcd_q;
        cnt_d         = cnt_q;
        t2_d          = t2_q;
        t1_d          = t1_q;
        t0_d          = t0_q;
        b1_d          = b1_q;
        b0_d          = b0_q;
        r1_d          = r1_q;
        r0_d          = r0_q;
        time_zero_d   = time_zero_q;
        frame_done_d  = 1'b0;
        blink_cnt_d   = blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q;
        sel           = 8'd0;
        adj           = 12'd0;
        dig_h         = bcd_q[11:8];
        dig_t         = bcd_q[7:4];
        dig_o         = bcd_q[3:0];

        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end

        case (state_q)
            ST_LOAD: begin
                case (ch_q)
                    CH_TIME: sel = time_left;
                    CH_BLUE: sel = {1'b0, blue_score};
                    default: sel = {1'b0, red_score};
                endcase
                // Scores only have two digits; time uses all three.
                if (ch_q != CH_TIME && sel > SCORE_MAX) begin
                    sel = SCORE_MAX;
                end
                bin_d   = sel;
                bcd_d   = 12'd0;
                cnt_d   = 3'd0;
                state_d = ST_SHIFT;
            end

            ST_SHIFT: begin
                adj            = bcd_adjust(bcd_q);
                {bcd_d, bin_d} = {adj, bin_q} << 1;
                cnt_d          = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = ST_STORE;
                end
            end

            ST_STORE: begin
                state_d = ST_LOAD;
                case (ch_q)
                    CH_TIME: begin
                        t2_d = (BLANK_LEADING_ZEROS && dig_h == 4'd0) ? SEG_BLANK : seg_encode(dig_h);
                        t1_d = (BLANK_LEADING_ZEROS && dig_h == 4'd0 && dig_t == 4'd0)
                               ? SEG_BLANK : seg_encode(dig_t);
                        t0_d = seg_encode(dig_o);
                        time_zero_d = (bcd_q == 12'd0);
                        ch_d = CH_BLUE;
                    end
                    CH_BLUE: begin
                        b1_d = (BLANK_LEADING_ZEROS && dig_t == 4'd0) ? SEG_BLANK : seg_encode(dig_t);
                        b0_d = seg_encode(dig_o);
                        ch_d = CH_RED;
                    end
                    default: begin
                        r1_d = (BLANK_LEADING_ZEROS && dig_t == 4'd0) ? SEG_BLANK : seg_encode(dig_t);
                        r0_d = seg_encode(dig_o);
                        frame_done_d = 1'b1;
                        ch_d = CH_TIME;
                    end
                endcase
            end

            default: state_d = ST_LOAD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_LOAD;
            ch_q          <= CH_TIME;
            bin_q         <= 8'd0;
            bcd_q         <= 12'd0;
            cnt_q         <= 3'd0;
            t2_q          <= SEG_BLANK;
            t1_q          <= SEG_BLANK;
            t0_q          <= SEG_BLANK;
            b1_q          <= SEG_BLANK;
            b0_q          <= SEG_BLANK;
            r1_q          <= SEG_BLANK;
            r0_q          <= SEG_BLANK;
            time_zero_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            bin_q         <= bin_d;
            bcd_q         <= bcd_d;
            cnt_q         <= cnt_d;
            t2_q          <= t2_d;
            t1_q          <= t1_d;
            t0_q          <= t0_d;
            b1_q          <= b1_d;
            b0_q          <= b0_d;
            r1_q          <= r1_d;
            r0_q          <= r0_d;
            time_zero_q   <= time_zero_d;
            frame_done_q  <= frame_done_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    // Blink masks the registered time digits; score digits never blink.
    logic time_blank;
    assign time_blank = time_zero_q & blink_phase_q;

    assign hex_time2  = time_blank ? SEG_BLANK : t2_q;
    assign hex_time1  = time_blank ? SEG_BLANK : t1_q;
    assign hex_time0  = time_blank ? SEG_BLANK : t0_q;
    assign hex_blue1  = b1_q;
    assign hex_blue0  = b0_q;
    assign hex_red1   = r1_q;
    assign hex_red0   = r0_q;
    assign frame_done = frame_done_q;

endmodule
